// File: rtl/oned_idct_if.sv
// Vector bundle for oned_idct: enable, eight coefficients in, eight samples out.
interface oned_idct_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 10
);
  logic                    en;
  logic                    in_valid;
  logic signed [IN_W-1:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  logic                    out_valid;
  logic signed [OUT_W-1:0] xo0, xo1, xo2, xo3, xo4, xo5, xo6, xo7;

  modport master (
    output en, in_valid, d0, d1, d2, d3, d4, d5, d6, d7,
    input  out_valid, xo0, xo1, xo2, xo3, xo4, xo5, xo6, xo7
  );

  modport slave (
    input  en, in_valid, d0, d1, d2, d3, d4, d5, d6, d7,
    output out_valid, xo0, xo1, xo2, xo3, xo4, xo5, xo6, xo7
  );
endinterface

// File: rtl/oned_idct.sv
// 8-point 1-D inverse DCT, 3-stage pipeline: input register, even/odd partial
// sums with constant multiplies, then butterfly with round-half-up and saturation.
module oned_idct #(
  parameter int IN_W      = 10,
  parameter int OUT_W     = 10,
  parameter int COEF_FRAC = 8
) (
  input logic        clk,
  input logic        rst,
  oned_idct_if.slave bus
);
  localparam int W = IN_W + 11;
  typedef logic signed [W-1:0] acc_t;

  // Cosine magnitudes in Q8, indexed by folded angle m = ((2n+1)k mod 16).
  localparam int C1 = 126;
  localparam int C2 = 118;
  localparam int C3 = 106;
  localparam int C4 = 91;
  localparam int C5 = 71;
  localparam int C6 = 49;
  localparam int C7 = 25;
  localparam int CDC = 91;

  // Signed coefficients for output n (0..3); output 7-n reuses them with odd terms negated.
  localparam int EV2 [4] = '{ C2,  C6, -C6, -C2};
  localparam int EV4 [4] = '{ C4, -C4, -C4,  C4};
  localparam int EV6 [4] = '{ C6, -C2,  C2, -C6};
  localparam int OD1 [4] = '{ C1,  C3,  C5,  C7};
  localparam int OD3 [4] = '{ C3, -C7, -C1, -C5};
  localparam int OD5 [4] = '{ C5, -C1,  C7,  C3};
  localparam int OD7 [4] = '{ C7, -C5,  C3, -C1};

  localparam acc_t RND    = acc_t'(1 << (COEF_FRAC - 1));
  localparam acc_t SAT_HI = acc_t'((1 << (OUT_W - 1)) - 1);
  localparam acc_t SAT_LO = acc_t'(-(1 << (OUT_W - 1)));

  function automatic logic signed [OUT_W-1:0] round_sat(input acc_t v);
    acc_t r;
    r = (v + RND) >>> COEF_FRAC;
    if (r > SAT_HI) begin
      r = SAT_HI;
    end else if (r < SAT_LO) begin
      r = SAT_LO;
    end
    return r[OUT_W-1:0];
  endfunction

  logic signed [IN_W-1:0]  din     [8];
  logic signed [IN_W-1:0]  s1_d    [8];
  logic                    s1_v;
  acc_t                    dx      [8];
  acc_t                    even_c  [4];
  acc_t                    odd_c   [4];
  acc_t                    s2_e    [4];
  acc_t                    s2_o    [4];
  logic                    s2_v;
  logic signed [OUT_W-1:0] xo_c    [8];
  logic signed [OUT_W-1:0] s3_x    [8];
  logic                    s3_v;

  always_comb begin
    din[0] = bus.d0;
    din[1] = bus.d1;
    din[2] = bus.d2;
    din[3] = bus.d3;
    din[4] = bus.d4;
    din[5] = bus.d5;
    din[6] = bus.d6;
    din[7] = bus.d7;
  end

  // Stage 1: input capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) s1_d[k] <= '0;
    end else if (bus.en) begin
      s1_v <= bus.in_valid;
      for (int unsigned k = 0; k < 8; k++) s1_d[k] <= din[k];
    end
  end

  // Stage 2: even/odd partial sums
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) dx[k] = acc_t'(s1_d[k]);
    for (int unsigned n = 0; n < 4; n++) begin
      even_c[n] = dx[0] * acc_t'(CDC)
                + dx[2] * acc_t'(EV2[n])
                + dx[4] * acc_t'(EV4[n])
                + dx[6] * acc_t'(EV6[n]);
      odd_c[n]  = dx[1] * acc_t'(OD1[n])
                + dx[3] * acc_t'(OD3[n])
                + dx[5] * acc_t'(OD5[n])
                + dx[7] * acc_t'(OD7[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      for (int unsigned n = 0; n < 4; n++) begin
        s2_e[n] <= '0;
        s2_o[n] <= '0;
      end
    end else if (bus.en) begin
      s2_v <= s1_v;
      for (int unsigned n = 0; n < 4; n++) begin
        s2_e[n] <= even_c[n];
        s2_o[n] <= odd_c[n];
      end
    end
  end

  // Stage 3: butterfly, round, saturate
  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      xo_c[n]     = round_sat(s2_e[n] + s2_o[n]);
      xo_c[7 - n] = round_sat(s2_e[n] - s2_o[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v <= 1'b0;
      for (int unsigned n = 0; n < 8; n++) s3_x[n] <= '0;
    end else if (bus.en) begin
      s3_v <= s2_v;
      for (int unsigned n = 0; n < 8; n++) s3_x[n] <= xo_c[n];
    end
  end

  assign bus.out_valid = s3_v;
  assign bus.xo0 = s3_x[0];
  assign bus.xo1 = s3_x[1];
  assign bus.xo2 = s3_x[2];
  assign bus.xo3 = s3_x[3];
  assign bus.xo4 = s3_x[4];
  assign bus.xo5 = s3_x[5];
  assign bus.xo6 = s3_x[6];
  assign bus.xo7 = s3_x[7];
endmodule

// File: tb/tb_oned_idct.sv
// Scoreboard bench for oned_idct: expected vectors come from a real-valued
// cosine model quantised to Q8, pushed at drive time and popped on out_valid.
module tb_oned_idct;
  localparam int IN_W  = 10;
  localparam int OUT_W = 10;
  localparam real PI   = 3.14159265358979;

  typedef logic signed [IN_W-1:0] vec_t [8];
  typedef logic [8*OUT_W-1:0] flat_t;

  logic clk = 1'b0;
  logic rst;

  oned_idct_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  oned_idct #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    coef [8][8];
  flat_t exp_q [$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic  prev_v;
  flat_t prev_x;
  vec_t  zv = '{default: '0};

  task automatic build_coef();
    real ck, v;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) begin
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 256.0 * (ck / 2.0) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        coef[n][k] = $rtoi($floor(v + 0.5));
      end
    end
  endtask

  function automatic flat_t model(input vec_t d);
    flat_t  r;
    longint acc;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 128;
      for (int k = 0; k < 8; k++) acc += longint'(coef[n][k]) * longint'(d[k]);
      acc = acc >>> 8;
      if (acc > 511) acc = 511;
      else if (acc < -512) acc = -512;
      r[n*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    end
    return r;
  endfunction

  // Forward DCT matching the encoder's scaling, rounded to integer coefficients.
  function automatic vec_t fdct(input int x [8]);
    vec_t X;
    real  s, ck;
    for (int k = 0; k < 8; k++) begin
      s = 0.0;
      for (int n = 0; n < 8; n++) s += real'(x[n]) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      X[k] = IN_W'($rtoi($floor(ck / 2.0 * s + 0.5)));
    end
    return X;
  endfunction

  function automatic flat_t got();
    return {bus.xo7, bus.xo6, bus.xo5, bus.xo4, bus.xo3, bus.xo2, bus.xo1, bus.xo0};
  endfunction

  task automatic drive(input vec_t d, input logic v, input logic e, input logic r);
    rst = r;
    bus.en = e;
    bus.in_valid = v;
    bus.d0 = d[0]; bus.d1 = d[1]; bus.d2 = d[2]; bus.d3 = d[3];
    bus.d4 = d[4]; bus.d5 = d[5]; bus.d6 = d[6]; bus.d7 = d[7];
    if (r) exp_q.delete();
    else if (e && v) exp_q.push_back(model(d));
  endtask

  task automatic test_reset();
    vec_t  d;
    flat_t dc23;
    d = zv;
    d[0] = 64;
    for (int i = 0; i < 8; i++) dc23[i*OUT_W +: OUT_W] = OUT_W'(23);
    drive(d, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0 || got() !== '0) begin
        n_bad++;
        $display("FAIL reset_state: got %b/%h required 0/0", bus.out_valid, got());
      end
    end
    drive(d, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) drive(zv, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (bus.out_valid !== (c == 3)) begin
        n_bad++;
        $display("FAIL latency: cycle %0d out_valid got %b required %b", c, bus.out_valid, c == 3);
      end
      if (c == 3) begin
        n_vec++;
        if (got() !== dc23) begin
          n_bad++;
          $display("FAIL dc: got %h required %h", got(), dc23);
        end
      end
      prev_v = bus.out_valid;
      prev_x = got();
    end
    exp_q.delete();
  endtask

  task automatic test_directed();
    vec_t  dv [4];
    int    ex0 [4] = '{23, 49, 511, -512};
    int    ex1 [4] = '{23, 41, -138, 138};
    int    ex7 [4] = '{23, -49, 511, -512};
    flat_t cap, e;
    for (int i = 0; i < 4; i++) dv[i] = zv;
    dv[0][0] = 64;
    dv[1][1] = 100;
    for (int k = 0; k < 8; k += 2) begin
      dv[2][k] = 511;
      dv[3][k] = -512;
    end
    for (int i = 0; i < 4; i++) begin
      cap = 'x;
      drive(dv[i], 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (c == 0) drive(zv, 1'b0, 1'b1, 1'b0);
        if (bus.out_valid) begin
          n_vec++;
          cap = got();
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL directed_extra: got out_valid with %h, required no output", got());
          end else begin
            e = exp_q.pop_front();
            if (got() !== e) begin
              n_bad++;
              $display("FAIL directed_model %0d: got %h required %h", i, got(), e);
            end
          end
        end
        prev_v = bus.out_valid;
        prev_x = got();
      end
      n_vec += 3;
      if (cap[0 +: OUT_W] !== OUT_W'(ex0[i])) begin
        n_bad++;
        $display("FAIL directed_xo0 %0d: got %h required %h", i, cap[0 +: OUT_W], OUT_W'(ex0[i]));
      end
      if (cap[OUT_W +: OUT_W] !== OUT_W'(ex1[i])) begin
        n_bad++;
        $display("FAIL directed_xo1 %0d: got %h required %h", i, cap[OUT_W +: OUT_W], OUT_W'(ex1[i]));
      end
      if (cap[7*OUT_W +: OUT_W] !== OUT_W'(ex7[i])) begin
        n_bad++;
        $display("FAIL directed_xo7 %0d: got %h required %h", i, cap[7*OUT_W +: OUT_W], OUT_W'(ex7[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t  sv [20];
    vec_t  junk;
    flat_t e;
    int    idx = 0;
    int    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (i % 2 == 0) sv[i][k] = IN_W'($urandom_range(0, 1023));
        else sv[i][k] = IN_W'(int'($urandom_range(0, 255)) - 128);
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!rst && !bus.en) begin
        n_vec++;
        if (bus.out_valid !== prev_v || got() !== prev_x) begin
          n_bad++;
          $display("FAIL stall_hold: got %b/%h required %b/%h", bus.out_valid, got(), prev_v, prev_x);
        end
      end else if (bus.out_valid) begin
        n_vec++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got out_valid with %h, required no output", got());
        end else begin
          e = exp_q.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL stream_data: got %h required %h", got(), e);
          end
        end
      end
      prev_v = bus.out_valid;
      prev_x = got();
      if (c >= 10 && c <= 12) begin
        for (int k = 0; k < 8; k++) junk[k] = IN_W'($urandom_range(0, 1023));
        drive(junk, 1'b1, 1'b0, 1'b0);
      end else if (idx < 20) begin
        drive(sv[idx], 1'b1, 1'b1, 1'b0);
        idx++;
      end else begin
        drive(zv, 1'b0, 1'b1, 1'b0);
      end
    end
    n_vec++;
    if (n_out != 20 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got %0d outputs (%0d pending) required 20 (0 pending)", n_out, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midstream();
    vec_t  d;
    flat_t e;
    int    n_out = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        n_vec++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL midrst_extra: got out_valid with %h, required no output", got());
        end else begin
          e = exp_q.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL midrst_data: got %h required %h", got(), e);
          end
        end
      end
      if (c == 7) begin
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL midrst_valid: got %b required 0", bus.out_valid);
        end
      end
      prev_v = bus.out_valid;
      prev_x = got();
      for (int k = 0; k < 8; k++) d[k] = IN_W'(int'($urandom_range(0, 511)) - 256);
      if (c < 6 || c == 10) drive(d, 1'b1, 1'b1, 1'b0);
      else if (c == 6) drive(d, 1'b1, 1'b0, 1'b1);
      else drive(zv, 1'b0, 1'b1, 1'b0);
    end
    n_vec++;
    if (n_out != 5 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_count: got %0d outputs (%0d pending) required 5 (0 pending)", n_out, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_round_trip();
    int    ramp [2][8] = '{'{1, 2, 3, 4, 5, 6, 7, 8}, '{10, 15, 20, 25, 30, 35, 40, 45}};
    flat_t caps [2];
    flat_t e;
    int    n_rt = 0;
    int    diff;
    logic signed [OUT_W-1:0] s;
    caps[0] = 'x;
    caps[1] = 'x;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        n_vec++;
        if (n_rt < 2) caps[n_rt] = got();
        n_rt++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rt_extra: got out_valid with %h, required no output", got());
        end else begin
          e = exp_q.pop_front();
          if (got() !== e) begin
            n_bad++;
            $display("FAIL rt_model: got %h required %h", got(), e);
          end
        end
      end
      prev_v = bus.out_valid;
      prev_x = got();
      if (c < 2) drive(fdct(ramp[c]), 1'b1, 1'b1, 1'b0);
      else drive(zv, 1'b0, 1'b1, 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        s = caps[r][i*OUT_W +: OUT_W];
        diff = int'(s) - ramp[r][i];
        if ($isunknown(s) || diff > 2 || diff < -2) begin
          n_bad++;
          $display("FAIL round_trip %0d[%0d]: got %0d required %0d +/-2", r, i, s, ramp[r][i]);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_coef();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
